// File: rtl/tmul_pkg.sv
// Shared types and constants for the TMUL A-matrix feeder.
//   fp16_t            : raw FP16 bit pattern (never interpreted here)
//   TMUL_LANES        : reduction depth / number of FMA row stages
//   TMUL_ROWS         : A rows per tile
//   tmul_feed_state_e : feeder sequencing states
package tmul_pkg;

    typedef logic [15:0] fp16_t;

    localparam int TMUL_LANES = 16;
    localparam int TMUL_ROWS  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } tmul_feed_state_e;

endpackage

// File: rtl/tmul_skew_lane.sv
// One lane of the triangular skew: a DEPTH-stage W-bit shift register that
// advances every cycle (the downstream chain never stalls).
//   clk    : clock
//   rst    : asynchronous active-low reset, clears every stage
//   din_i  : element injected this cycle (zero for a bubble)
//   dout_o : last stage, i.e. din_i delayed by DEPTH cycles
module tmul_skew_lane #(
    parameter int DEPTH = 1,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);

    logic [W-1:0] stage_q [DEPTH];

    // Shift chain: stage 0 captures the input, later stages follow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/tmul_a_feeder.sv
// Upstream feeder for the 16-stage FP16 FMA row chain. Accepts one A row per
// cycle (valid/ready), skews element k by k cycles into a_out[k], and carries
// a {valid, idx} tag alongside so res_valid/res_idx line up with the chain's
// final RowProduct. Sequences one tile: IDLE -> STREAM -> DRAIN -> IDLE.
//   clk, rst   : clock, asynchronous active-low reset
//   start      : begin a tile (only honoured in IDLE)
//   in_valid   : in_row valid;  in_ready : row accepted when both high
//   in_row     : A row, element k at bits [k*W +: W]
//   a_out      : skewed elements, a_out[k] feeds chain stage k
//   res_valid  : RowProduct holds a real row this cycle; res_idx its row
//   busy       : not IDLE;  tile_done : pulse with the tile's last res_valid
module tmul_a_feeder
    import tmul_pkg::*;
#(
    parameter int LANES = TMUL_LANES,
    parameter int ROWS  = TMUL_ROWS,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*W-1:0]       in_row,
    output logic [W-1:0]             a_out [LANES-1:0],
    output logic                     res_valid,
    output logic [$clog2(ROWS)-1:0]  res_idx,
    output logic                     busy,
    output logic                     tile_done
);

    localparam int IDX_W  = $clog2(ROWS);
    localparam int DCNT_W = $clog2(LANES);

    tmul_feed_state_e    state_q;
    logic [IDX_W-1:0]    row_cnt_q;
    logic [DCNT_W-1:0]   drain_cnt_q;
    logic                tile_done_q;
    logic                accept_s;
    logic [W-1:0]        inj_s [LANES];
    logic                tag_valid_q [LANES];
    logic [IDX_W-1:0]    tag_idx_q   [LANES];

    assign in_ready  = (state_q == ST_STREAM);
    assign accept_s  = in_valid & in_ready;
    assign busy      = (state_q != ST_IDLE);
    assign tile_done = tile_done_q;
    assign res_valid = tag_valid_q[LANES-1];
    assign res_idx   = tag_idx_q[LANES-1];

    // Lane k gets k+1 stages so its element arrives k cycles after lane 0.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign inj_s[k] = accept_s ? in_row[k*W +: W] : {W{1'b0}};

        tmul_skew_lane #(
            .DEPTH (k + 1),
            .W     (W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .din_i  (inj_s[k]),
            .dout_o (a_out[k])
        );
    end

    // Tile sequencer with row/drain counters and the registered done pulse.
    // tile_done is raised on the edge where drain_cnt reaches LANES-1 so it
    // lands in the same cycle as the last row's res_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            row_cnt_q   <= '0;
            drain_cnt_q <= '0;
            tile_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tile_done_q <= 1'b0;
                    if (start) begin
                        state_q   <= ST_STREAM;
                        row_cnt_q <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    tile_done_q <= 1'b0;
                    if (accept_s) begin
                        row_cnt_q <= row_cnt_q + IDX_W'(1);
                        if (row_cnt_q == IDX_W'(ROWS - 1)) begin
                            state_q     <= ST_DRAIN;
                            drain_cnt_q <= '0;
                        end else begin
                            state_q <= ST_STREAM;
                        end
                    end else begin
                        state_q <= ST_STREAM;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_q <= drain_cnt_q + DCNT_W'(1);
                    tile_done_q <= (drain_cnt_q == DCNT_W'(LANES - 2));
                    if (drain_cnt_q == DCNT_W'(LANES - 1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    tile_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Tag pipeline: bubbles carry valid=0 and idx=0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) begin
                tag_valid_q[i] <= 1'b0;
                tag_idx_q[i]   <= '0;
            end
        end else begin
            tag_valid_q[0] <= accept_s;
            tag_idx_q[0]   <= accept_s ? row_cnt_q : {IDX_W{1'b0}};
            for (int i = 1; i < LANES; i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_idx_q[i]   <= tag_idx_q[i-1];
            end
        end
    end

endmodule
